// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file: state encoding,
// default sizing constants and the hardwired-zero register address.
package rf_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int ADDR_ZERO    = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, a new load's set
// beats a same-cycle completing write's clear, and x0 is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pend_set,
    input  logic [AW-1:0] pend_addr,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          pend_hit1,
    output logic          pend_hit2
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Clear is applied first so that a set to the same address overrides it.
    always_comb begin
        pend_d = pend_q;
        if (we && (wr_addr != AW'(ADDR_ZERO))) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (pend_set && (pend_addr != AW'(ADDR_ZERO))) begin
            pend_d[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_hit1 = (rs1_addr != AW'(ADDR_ZERO)) && pend_q[rs1_addr];
    assign pend_hit2 = (rs2_addr != AW'(ADDR_ZERO)) && pend_q[rs2_addr];

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register file with post-reset init engine, hardwired x0 and a
// load-use scoreboard. Define RF_BYPASS_EN to enable write-through forwarding.
module banco_registradores_param
    import rf_pkg::*;
#(
    parameter int  XLEN       = RF_XLEN_DEF,
    parameter int  NREGS      = RF_NREGS_DEF,
    parameter bit  INIT_INDEX = 1'b1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            pend_set,
    input  logic [AW-1:0]   pend_addr,
    output logic            hazard,
    output logic            ready
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] init_val;
    logic            run;
    logic            we_run;
    logic            pend_set_run;
    logic            wr_hit1, wr_hit2;
    logic            pend_hit1, pend_hit2;

    assign run          = (state_q == RF_RUN);
    assign we_run       = we && run;
    assign pend_set_run = pend_set && run;
    assign init_val     = INIT_INDEX ? XLEN'(cnt_q) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    // The array has no reset; the init engine owns it until RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == RF_INIT) begin
                rf_q[cnt_q] <= init_val;
            end else if (we && (wr_addr != AW'(ADDR_ZERO))) begin
                rf_q[wr_addr] <= wr_data;
            end
        end
    end

    assign wr_hit1 = we_run && (wr_addr == rs1_addr) && (wr_addr != AW'(ADDR_ZERO));
    assign wr_hit2 = we_run && (wr_addr == rs2_addr) && (wr_addr != AW'(ADDR_ZERO));

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != AW'(ADDR_ZERO)) begin
            rs1_data = rf_q[rs1_addr];
        end
        if (rs2_addr != AW'(ADDR_ZERO)) begin
            rs2_data = rf_q[rs2_addr];
        end
`ifdef RF_BYPASS_EN
        if (wr_hit1) begin
            rs1_data = wr_data;
        end
        if (wr_hit2) begin
            rs2_data = wr_data;
        end
`endif
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .pend_set  (pend_set_run),
        .pend_addr (pend_addr),
        .we        (we_run),
        .wr_addr   (wr_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2)
    );

    // Without forwarding, a source being written this cycle must also stall.
    always_comb begin
        hazard = 1'b1;
        if (run) begin
`ifdef RF_BYPASS_EN
            hazard = (pend_hit1 && !wr_hit1) || (pend_hit2 && !wr_hit2);
`else
            hazard = (pend_hit1 && !wr_hit1) || (pend_hit2 && !wr_hit2) ||
                     wr_hit1 || wr_hit2;
`endif
        end
    end

    assign ready = run;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed self-checking bench for banco_registradores_param with default
// parameters; expectations follow RF_BYPASS_EN when it is defined.
module tb_banco_registradores_param;

    logic        clock;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        hazard;
    logic        ready;

    int checks = 0;
    int errors = 0;

    banco_registradores_param dut (
        .clock     (clock),
        .reset     (reset),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .hazard    (hazard),
        .ready     (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic idle_inputs();
        we = 1'b0; wr_addr = '0; wr_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic wait_ready(input string name, input int expected);
        int cycles = 0;
        while (!ready && cycles < 200) begin
            @(negedge clock);
            cycles++;
        end
        #1;
        checks++;
        if (cycles !== expected) begin
            errors++;
            $display("[TB] FAIL %s: cycles until ready %0d, required %0d", name, cycles, expected);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (ready !== 1'b0 || hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b hazard=%b, required ready=0 hazard=1", ready, hazard);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_release: ready=%b, required 0", ready);
        end
    endtask

    task automatic test_init();
        wait_ready("init_length", 32);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1_data !== 32'(i) || rs2_data !== 32'(31 - i)) begin
                errors++;
                $display("[TB] FAIL init_read[%0d]: rs1=%0d rs2=%0d, required %0d and %0d",
                         i, rs1_data, rs2_data, i, 31 - i);
            end
        end
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_hazard_idle: hazard=%b, required 0", hazard);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] exp_data;
        logic        exp_haz;
        @(negedge clock);
        idle_inputs();
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
`ifdef RF_BYPASS_EN
        exp_data = 32'hDEADBEEF; exp_haz = 1'b0;
`else
        exp_data = 32'd5; exp_haz = 1'b1;
`endif
        #1;
        checks++;
        if (rs1_data !== exp_data || hazard !== exp_haz) begin
            errors++;
            $display("[TB] FAIL write_same_cycle: rs1=%h hazard=%b, required %h %b", rs1_data, hazard, exp_data, exp_haz);
        end
        @(negedge clock);
        we = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_next_cycle: rs1=%h hazard=%b, required deadbeef 0", rs1_data, hazard);
        end
    endtask

    task automatic test_x0();
        @(negedge clock);
        idle_inputs();
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        pend_set = 1'b1; pend_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'd0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_same_cycle: rs1=%h hazard=%b, required 0 0", rs1_data, hazard);
        end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_after: rs1=%h rs2=%h hazard=%b, required 0 0 0", rs1_data, rs2_data, hazard);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] exp_data;
        logic        exp_haz;
        @(negedge clock);
        idle_inputs();
        pend_set = 1'b1; pend_addr = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pend_not_yet: hazard=%b, required 0", hazard);
        end
        @(negedge clock);
        pend_set = 1'b0; rs2_addr = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_hazard: hazard=%b, required 1", hazard);
        end
        @(negedge clock);
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_hold: hazard=%b, required 1", hazard);
        end
        @(negedge clock);
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
`ifdef RF_BYPASS_EN
        exp_data = 32'h1234; exp_haz = 1'b0;
`else
        exp_data = 32'd7; exp_haz = 1'b1;
`endif
        #1;
        checks++;
        if (rs2_data !== exp_data || hazard !== exp_haz) begin
            errors++;
            $display("[TB] FAIL load_use_writeback: rs2=%h hazard=%b, required %h %b", rs2_data, hazard, exp_data, exp_haz);
        end
        @(negedge clock);
        we = 1'b0;
        #1;
        checks++;
        if (rs2_data !== 32'h1234 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_use_done: rs2=%h hazard=%b, required 1234 0", rs2_data, hazard);
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        idle_inputs();
        pend_set = 1'b1; pend_addr = 5'd9;
        @(negedge clock);
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        @(negedge clock);
        idle_inputs();
        rs1_addr = 5'd9;
        #1;
        checks++;
        if (hazard !== 1'b1 || rs1_data !== 32'h99) begin
            errors++;
            $display("[TB] FAIL collision_set_wins: hazard=%b rs1=%h, required 1 99", hazard, rs1_data);
        end
        @(negedge clock);
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h77; rs1_addr = 5'd0;
        @(negedge clock);
        idle_inputs();
        rs1_addr = 5'd9;
        #1;
        checks++;
        if (hazard !== 1'b0 || rs1_data !== 32'h77) begin
            errors++;
            $display("[TB] FAIL collision_cleared: hazard=%b rs1=%h, required 0 77", hazard, rs1_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        idle_inputs();
        pend_set = 1'b1; pend_addr = 5'd3;
        @(negedge clock);
        pend_addr = 5'd4;
        @(negedge clock);
        pend_set = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pend_3_4: hazard=%b, required 1", hazard);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        checks++;
        if (ready !== 1'b0 || hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_init: ready=%b hazard=%b, required 0 1", ready, hazard);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        // Loads issued during init must be ignored.
        pend_set = 1'b1; pend_addr = 5'd12;
        wait_ready("reinit_length", 32);
        pend_set = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || rs1_data !== 32'd3 || rs2_data !== 32'd4) begin
            errors++;
            $display("[TB] FAIL reinit_reads: hazard=%b rs1=%h rs2=%h, required 0 3 4", hazard, rs1_data, rs2_data);
        end
        rs1_addr = 5'd12;
        #1;
        checks++;
        if (hazard !== 1'b0 || rs1_data !== 32'd12) begin
            errors++;
            $display("[TB] FAIL init_ignores_pend: hazard=%b rs1=%h, required 0 c", hazard, rs1_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_init();
        test_write_read();
        test_x0();
        test_load_use();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
